// File: rtl/aes_pkg.sv
// Shared AES definitions: round-count helpers, FSM states, GF(2^8) arithmetic,
// S-box and the single-round primitive used by the iterative core.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned rounds_for(int unsigned key_size);
    return key_size / 32 + 6;
  endfunction

  function automatic int unsigned nk_for(int unsigned key_size);
    return key_size / 32;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box evaluated as multiplicative inverse (x^254) followed by the affine map;
  // produces the same 256-entry table as the FIPS-197 listing.
  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES round: SubBytes, ShiftRows, MixColumns (skipped when fin), AddRoundKey.
  // Byte i of the block sits at [127-8i -: 8]; byte index = row + 4*column.
  function automatic logic [127:0] aes_round(logic [127:0] st, logic [127:0] rk, logic fin);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int unsigned i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        t[r+4*c] = s[r+4*((c+r)%4)];
    if (!fin) begin
      for (int unsigned c = 0; c < 4; c++) begin
        a0 = t[4*c];
        a1 = t[4*c+1];
        a2 = t[4*c+2];
        a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int unsigned i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res ^ rk;
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// Combinational chain of UNROLL AES rounds; per-round flag selects the final round.
module aes_round_step
  import aes_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic [127:0]       st_in,
  input  logic [127:0]       rk [0:UNROLL-1],
  input  logic [UNROLL-1:0]  last,
  output logic [127:0]       st_out
);

  logic [127:0] s;

  // Apply the rounds in order, each with its own key and final flag.
  always_comb begin
    s = st_in;
    for (int unsigned k = 0; k < UNROLL; k++) s = aes_round(s, rk[k], last[k]);
    st_out = s;
  end

endmodule

// File: rtl/key_gen.sv
// Combinational AES key expansion: produces every round key from the cipher key.
module key_gen
  import aes_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 128
) (
  input  logic [KEY_SIZE-1:0] key,
  output logic [127:0]        rk [0:rounds_for(KEY_SIZE)]
);

  localparam int unsigned NR = rounds_for(KEY_SIZE);
  localparam int unsigned NK = nk_for(KEY_SIZE);
  localparam int unsigned NW = 4 * (NR + 1);

  logic [31:0] w [NW];
  logic [31:0] tmp;
  logic [7:0]  rcon;

  // Expand the key word by word, then group four words per round key.
  always_comb begin
    rcon = 8'h01;
    tmp  = '0;
    for (int unsigned i = 0; i < NK; i++) w[i] = key[KEY_SIZE-1-32*i -: 32];
    for (int unsigned i = NK; i < NW; i++) begin
      tmp = w[i-1];
      if (i % NK == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if (NK > 6 && i % NK == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-NK] ^ tmp;
    end
    for (int unsigned j = 0; j <= NR; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryptor, UNROLL rounds per clock, valid/ready on both sides.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 128,
  parameter int unsigned UNROLL   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        pt,
  input  logic [KEY_SIZE-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ct,
  output logic                busy
);

  localparam int unsigned ROUNDS = rounds_for(KEY_SIZE);
  localparam int unsigned RCW    = $clog2(ROUNDS + 1);

  if (!(KEY_SIZE == 128 || KEY_SIZE == 192 || KEY_SIZE == 256)) begin : g_bad_key_size
    $error("aes_enc_iter: KEY_SIZE must be 128, 192 or 256");
  end
  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("aes_enc_iter: UNROLL must be 1 or 2");
  end

  state_t              state;
  logic [127:0]        st_q;
  logic [KEY_SIZE-1:0] key_reg;
  logic [RCW-1:0]      rc;
  logic [127:0]        rk_all [0:ROUNDS];
  logic [127:0]        rk_sel [0:UNROLL-1];
  logic [UNROLL-1:0]   last;
  logic [127:0]        step_out;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  key_gen #(.KEY_SIZE(KEY_SIZE)) u_key_gen (
    .key (key_reg),
    .rk  (rk_all)
  );

  // Pick round keys rc+1 .. rc+UNROLL and flag the final round.
  always_comb begin
    for (int unsigned k = 0; k < UNROLL; k++) begin
      rk_sel[k] = '0;
      last[k]   = 1'b0;
      if (32'(rc) + k + 1 <= ROUNDS) begin
        rk_sel[k] = rk_all[32'(rc) + k + 1];
        last[k]   = (32'(rc) + k + 1 == ROUNDS);
      end
    end
  end

  aes_round_step #(.UNROLL(UNROLL)) u_round_step (
    .st_in  (st_q),
    .rk     (rk_sel),
    .last   (last),
    .st_out (step_out)
  );

  // Control FSM with block state, key latch, round counter and registered outputs.
  // Round key 0 at acceptance comes straight from the key port, since key_reg
  // only holds the new key after this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      st_q      <= '0;
      key_reg   <= '0;
      rc        <= '0;
      ct        <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key_reg <= key;
            st_q    <= pt ^ key[KEY_SIZE-1 -: 128];
            rc      <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          st_q <= step_out;
          rc   <= rc + RCW'(UNROLL);
          if (rc + RCW'(UNROLL) == RCW'(ROUNDS)) begin
            ct        <= step_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter across all key sizes and both unroll factors.
module tb_aes_enc_iter;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid_a  [N];
  logic         in_ready_a  [N];
  logic         out_valid_a [N];
  logic         out_ready_a [N];
  logic         clr_a       [N];
  logic         busy_a      [N];
  logic [127:0] pt_a        [N];
  logic [127:0] ct_a        [N];
  logic [255:0] key_a       [N];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sbt [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned KS = (g % 3 == 0) ? 128 : ((g % 3 == 1) ? 192 : 256);
    localparam int unsigned UN = (g / 3) + 1;
    aes_enc_iter #(.KEY_SIZE(KS), .UNROLL(UN)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_a[g]),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .pt        (pt_a[g]),
      .key       (key_a[g][255 -: KS]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .ct        (ct_a[g]),
      .busy      (busy_a[g])
    );
  end

  function automatic int ks_of(int g);
    return (g % 3 == 0) ? 128 : ((g % 3 == 1) ? 192 : 256);
  endfunction

  function automatic int lat_of(int g);
    return (ks_of(g) / 32 + 6) / (g / 3 + 1);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[x] = s;
    end
  endtask

  function automatic logic [127:0] model_enc(logic [255:0] key, int ks, logic [127:0] pt);
    logic [7:0] w [60][4];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rcv, x, a0, a1, a2, a3;
    logic [127:0] res;
    int nk = ks / 32;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[255-8*(4*i+j) -: 8];
    rcv = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % nk == 0) begin
        x = tmp[0];
        tmp[0] = sbt[tmp[1]] ^ rcv;
        tmp[1] = sbt[tmp[2]];
        tmp[2] = sbt[tmp[3]];
        tmp[3] = sbt[x];
        rcv = gmul(rcv, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbt[tmp[j]];
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ tmp[j];
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][j%4];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int j = 0; j < 16; j++) t[j] = sbt[s[j]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rd + j/4][j%4];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking and driving ----------------
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a block when the core is ready; returns at the negedge after the accept edge.
  task automatic send(int d, logic [255:0] k, logic [127:0] p);
    int n = 0;
    @(negedge clk);
    while (!in_ready_a[d] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", {255'd0, in_ready_a[d]}, 256'd1);
    in_valid_a[d] = 1'b1;
    pt_a[d]       = p;
    key_a[d]      = k;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[d] = 1'b0;
    pt_a[d]       = rand128();
    key_a[d]      = rand256();
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(int d, output int lat);
    lat = 0;
    while (!out_valid_a[d] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_one(int d, logic [255:0] k, logic [127:0] p, logic [127:0] exp, string tag);
    int lat;
    send(d, k, p);
    chk({tag, "_busy"}, {255'd0, busy_a[d]}, 256'd1);
    wait_out(d, lat);
    chk({tag, "_latency"}, 256'(lat), 256'(lat_of(d)));
    chk({tag, "_ct"}, {128'd0, ct_a[d]}, {128'd0, exp});
    @(negedge clk);
    chk({tag, "_valid_drop"}, {255'd0, out_valid_a[d]}, 256'd0);
    chk({tag, "_idle_ready"}, {255'd0, in_ready_a[d]}, 256'd1);
  endtask

  logic [255:0] kc [3];
  logic [127:0] ec [3];
  logic [127:0] pc;

  initial begin
    int lat, pulses, idx, nout, cyc;
    int acc [4];
    logic adv;
    logic [255:0] bk [4];
    logic [127:0] bp [4];
    logic [127:0] be [4];
    logic [127:0] got [4];
    logic [127:0] saved, exp;
    logic [255:0] k;
    logic [127:0] p;

    for (int g = 0; g < N; g++) begin
      in_valid_a[g] = 1'b0; out_ready_a[g] = 1'b1; clr_a[g] = 1'b0;
      pt_a[g] = '0; key_a[g] = '0;
    end
    build_sbox();
    pc    = 128'h00112233445566778899aabbccddeeff;
    kc[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    kc[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    kc[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    ec[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ec[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    ec[2] = 128'h8ea2b7ca516745bfeafc49904b496089;

    // reset
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {255'd0, in_ready_a[0]}, 256'd1);
    chk("rst_out_valid", {255'd0, out_valid_a[0]}, 256'd0);
    chk("rst_busy", {255'd0, busy_a[0]}, 256'd0);
    chk("rst_ct", {128'd0, ct_a[0]}, 256'd0);
    rst = 1'b1;

    // FIPS-197 Appendix B example
    run_one(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
            128'h3243f6a8885a308d313198a2e0370734,
            128'h3925841d02dc09fbdc118597196a0b32, "appB");

    // Appendix C vectors on every key size and unroll factor
    for (int g = 0; g < N; g++) run_one(g, kc[g % 3], pc, ec[g % 3], $sformatf("appC_%0d", g));

    // random blocks against the reference model
    for (int g = 0; g < N; g++)
      for (int r = 0; r < 3; r++) begin
        k = rand256();
        p = rand128();
        run_one(g, k, p, model_enc(k, ks_of(g), p), $sformatf("rand_%0d_%0d", g, r));
      end

    // backpressure: hold out_ready low and wiggle the inputs
    out_ready_a[0] = 1'b0;
    k = rand256();
    p = rand128();
    send(0, k, p);
    wait_out(0, lat);
    chk("bp_latency", 256'(lat), 256'd10);
    saved = ct_a[0];
    chk("bp_ct", {128'd0, saved}, {128'd0, model_enc(k, 128, p)});
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid_hold", {255'd0, out_valid_a[0]}, 256'd1);
      chk("bp_ct_hold", {128'd0, ct_a[0]}, {128'd0, saved});
      chk("bp_in_ready_low", {255'd0, in_ready_a[0]}, 256'd0);
      in_valid_a[0] = 1'b1;
      pt_a[0]       = rand128();
      key_a[0]      = rand256();
      @(negedge clk);
    end
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {255'd0, out_valid_a[0]}, 256'd0);
    chk("bp_release_ready", {255'd0, in_ready_a[0]}, 256'd1);
    chk("bp_release_ct", {128'd0, ct_a[0]}, {128'd0, saved});

    // back-to-back blocks with the source always valid
    bk[0] = kc[0]; bp[0] = pc; be[0] = ec[0];
    for (int i = 1; i < 4; i++) begin
      bk[i] = rand256(); bp[i] = rand128(); be[i] = model_enc(bk[i], 128, bp[i]);
    end
    idx = 0; nout = 0; cyc = 0; adv = 1'b0;
    @(negedge clk);
    in_valid_a[0] = 1'b1; key_a[0] = bk[0]; pt_a[0] = bp[0];
    while (nout < 4 && cyc < 200) begin
      if (in_valid_a[0] && in_ready_a[0] && idx < 4) begin
        acc[idx] = cyc;
        idx++;
        adv = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (out_valid_a[0]) begin
        got[nout] = ct_a[0];
        nout++;
      end
      if (adv) begin
        adv = 1'b0;
        if (idx < 4) begin
          key_a[0] = bk[idx]; pt_a[0] = bp[idx];
        end else begin
          in_valid_a[0] = 1'b0;
        end
      end
    end
    in_valid_a[0] = 1'b0;
    chk("b2b_count", 256'(nout), 256'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_ct_%0d", i), {128'd0, got[i]}, {128'd0, be[i]});
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_spacing_%0d", i), 256'(acc[i+1] - acc[i]), 256'd12);

    // abort during RUN
    send(0, rand256(), rand128());
    repeat (3) @(negedge clk);
    clr_a[0] = 1'b1;
    @(negedge clk);
    clr_a[0] = 1'b0;
    chk("clr_run_ready", {255'd0, in_ready_a[0]}, 256'd1);
    chk("clr_run_busy", {255'd0, busy_a[0]}, 256'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid_a[0]) pulses++;
      @(negedge clk);
    end
    chk("clr_run_no_pulse", 256'(pulses), 256'd0);

    // abort coincident with the output handshake
    send(0, rand256(), rand128());
    wait_out(0, lat);
    chk("clr_done_latency", 256'(lat), 256'd10);
    clr_a[0] = 1'b1;
    @(negedge clk);
    clr_a[0] = 1'b0;
    chk("clr_done_valid", {255'd0, out_valid_a[0]}, 256'd0);
    chk("clr_done_ready", {255'd0, in_ready_a[0]}, 256'd1);
    k = rand256(); p = rand128();
    run_one(0, k, p, model_enc(k, 128, p), "after_clr");

    // asynchronous reset in the middle of RUN
    send(0, rand256(), rand128());
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", {255'd0, in_ready_a[0]}, 256'd1);
    chk("arst_out_valid", {255'd0, out_valid_a[0]}, 256'd0);
    chk("arst_busy", {255'd0, busy_a[0]}, 256'd0);
    chk("arst_ct", {128'd0, ct_a[0]}, 256'd0);
    @(negedge clk);
    rst = 1'b1;
    k = rand256(); p = rand128();
    exp = model_enc(k, 256, p);
    run_one(5, k, p, exp, "after_rst_u2");
    run_one(0, kc[0], pc, ec[0], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
